// File: rtl/eg_encoder.sv
// Exp-Golomb style serial encoder: a small input FIFO of 4-bit values feeds a
// serializer that emits N ones, a zero, then the N low bits of (v+1) MSB first.
module eg_encoder #(
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pi_valid,
  input  logic [3:0] pi_data,
  output logic       pi_ready,
  input  logic       so_stall,
  output logic       so_valid,
  output logic       so_data,
  output logic       so_last,
  output logic       err,
  output logic       busy
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [CntW-1:0] FullCnt = CntW'(FIFO_DEPTH);

  typedef enum logic [1:0] {StIdle, StPrefix, StStop, StSuffix} state_e;

  logic [3:0]      mem [FIFO_DEPTH];
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0] count_q;
  logic            fifo_empty, push, pop;

  state_e          state_q, state_d;
  logic [1:0]      n_q, n_d;
  logic [2:0]      suf_q, suf_d;
  logic [1:0]      idx_q, idx_d;
  logic            err_q;
  logic            consume, cw_end;
  logic [3:0]      head_w;
  logic [1:0]      head_n;

  assign fifo_empty = (count_q == '0);
  // Ready is gated by reset so it drops the instant reset asserts.
  assign pi_ready   = rst & (count_q != FullCnt);
  // Illegal value 15 is never written; it only raises err.
  assign push       = pi_valid & pi_ready & (pi_data != 4'd15);
  assign head_w     = mem[rd_ptr_q] + 4'd1;

  assign so_valid = (state_q != StIdle);
  assign consume  = so_valid & ~so_stall;
  assign err      = err_q;
  assign busy     = ~fifo_empty | (state_q != StIdle);

  // Prefix length of the head value: floor(log2(v+1)).
  always_comb begin
    head_n = 2'd0;
    if (head_w[3])      head_n = 2'd3;
    else if (head_w[2]) head_n = 2'd2;
    else if (head_w[1]) head_n = 2'd1;
  end

  // Serializer next state and serial outputs.
  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    suf_d   = suf_q;
    idx_d   = idx_q;
    pop     = 1'b0;
    cw_end  = 1'b0;
    so_data = 1'b0;
    so_last = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (!fifo_empty) pop = 1'b1;
      end
      StPrefix: begin
        so_data = 1'b1;
        if (consume) begin
          if (idx_q == 2'd0) state_d = StStop;
          else               idx_d   = idx_q - 2'd1;
        end
      end
      StStop: begin
        so_last = (n_q == 2'd0);
        if (consume) begin
          if (n_q != 2'd0) begin
            state_d = StSuffix;
            idx_d   = n_q - 2'd1;
          end else begin
            cw_end = 1'b1;
          end
        end
      end
      StSuffix: begin
        so_data = suf_q[idx_q];
        so_last = (idx_q == 2'd0);
        if (consume) begin
          if (idx_q == 2'd0) cw_end = 1'b1;
          else               idx_d  = idx_q - 2'd1;
        end
      end
      default: ;
    endcase
    // Back-to-back codewords: load the next value on the final consumed bit.
    if (cw_end) begin
      state_d = StIdle;
      if (!fifo_empty) pop = 1'b1;
    end
    if (pop) begin
      n_d     = head_n;
      suf_d   = head_w[2:0];
      idx_d   = head_n - 2'd1;
      state_d = (head_n != 2'd0) ? StPrefix : StStop;
    end
  end

  // Serializer and error-pulse registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      n_q     <= 2'd0;
      suf_q   <= 3'd0;
      idx_q   <= 2'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      suf_q   <= suf_d;
      idx_q   <= idx_d;
      err_q   <= pi_valid & pi_ready & (pi_data == 4'd15);
    end
  end

  // FIFO pointers and occupancy; power-of-two depth makes pointers wrap naturally.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + CntW'(1);
        2'b01:   count_q <= count_q - CntW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // FIFO storage; contents are don't-care while empty so no reset.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= pi_data;
  end

endmodule
